// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int MULT_ITERS = 16;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W = 6;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
endpackage

// File: rtl/booth_radix4_select.sv
// booth_radix4_select: maps a radix-4 Booth group to a 33-bit addend of 0, +-A or +-2A.
// Negative addends come out one's-complemented with neg set; the adder supplies the +1.
module booth_radix4_select (
    input  logic [2:0]  grp,
    input  logic [31:0] a,
    output logic [32:0] addend,
    output logic        neg
);
    logic [32:0] mag;
    always_comb begin
        mag = (grp == 3'b011 || grp == 3'b100) ? {a, 1'b0} :
              (grp == 3'b000 || grp == 3'b111) ? 33'b0 : {a[31], a};
        neg = grp[2] & ~(&grp);
        addend = neg ? ~mag : mag;
    end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit radix-4 Booth multiplier and non-restoring divider.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    import multdiv_pkg::*;

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0] opa, quo, quo_nx, res;
    logic [64:0] prod, prod_nx;
    logic [33:0] rem, rem_nx, rs, sum;
    logic [32:0] addend;
    logic bm1, neg, q_neg, ovf, exc, dz, last;

    booth_radix4_select u_sel (
        .grp   ({prod[1:0], bm1}),
        .a     (opa),
        .addend(addend),
        .neg   (neg)
    );

    // 34-bit sum keeps -2*INT_MIN representable before the arithmetic shift
    assign sum = {prod[64], prod[64:32]} + {addend[32], addend} + {33'b0, neg};
    assign prod_nx = {sum[33], sum, prod[31:2]};
    assign rs = {rem[32:0], quo[31]};
    assign rem_nx = rem[33] ? rs + {2'b0, opa} : rs - {2'b0, opa};
    assign quo_nx = {quo[30:0], ~rem_nx[33]};
    assign dz = ctrl_DIV & ~ctrl_MULT & (data_operandB == '0);
    assign last = cnt == CNT_W'(state == MULT ? MULT_ITERS - 1 : DIV_ITERS - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ctrl_MULT) state_nx = MULT;
        else if (ctrl_DIV) state_nx = dz ? DONE : DIV;
        else if ((state == MULT || state == DIV) && last) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            opa <= '0;
            prod <= '0;
            bm1 <= 1'b0;
            rem <= '0;
            quo <= '0;
            q_neg <= 1'b0;
            ovf <= 1'b0;
            res <= '0;
            exc <= 1'b0;
        end else if (ctrl_MULT) begin
            cnt <= '0;
            opa <= data_operandA;
            prod <= {33'b0, data_operandB};
            bm1 <= 1'b0;
        end else if (ctrl_DIV) begin
            cnt <= '0;
            opa <= data_operandB[31] ? -data_operandB : data_operandB;
            quo <= data_operandA[31] ? -data_operandA : data_operandA;
            rem <= '0;
            q_neg <= data_operandA[31] ^ data_operandB[31];
            ovf <= data_operandA == INT_MIN && data_operandB == '1;
            if (dz) begin
                res <= '0;
                exc <= 1'b1;
            end
        end else if (state == MULT) begin
            cnt <= cnt + 1'b1;
            prod <= prod_nx;
            bm1 <= prod[1];
            if (last) begin
                res <= prod_nx[31:0];
                exc <= ~(&prod_nx[63:31] | ~|prod_nx[63:31]);
            end
        end else if (state == DIV) begin
            cnt <= cnt + 1'b1;
            rem <= rem_nx;
            quo <= quo_nx;
            if (last) begin
                res <= q_neg ? -quo_nx : quo_nx;
                exc <= ovf;
            end
        end
    end

    assign data_result = res;
    assign data_exception = exc;
    assign data_resultRDY = state == DONE;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed self-checking bench for multdiv_unit.
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ctrl_MULT = 1'b0;
    logic ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic data_exception;
    logic data_resultRDY;
    int checks = 0;
    int errors = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; pulses start, scrambles operands afterwards,
    // and checks RDY appears only in cycle lat with the expected outputs.
    task automatic op(input string tag, input logic m, input logic d, input logic [31:0] a,
                      input logic [31:0] b, input int lat, input logic [31:0] er,
                      input logic ee, input logic tail);
        int early;
        early = 0;
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = 1'b0;
            data_operandA = 32'hDEAD_BEEF;
            data_operandB = 32'h1234_5678;
            if (c < lat && data_resultRDY) early++;
        end
        chk({tag, "_early"}, early, 0);
        chk({tag, "_rdy"}, data_resultRDY, 1);
        chk({tag, "_res"}, data_result, er);
        chk({tag, "_exc"}, data_exception, ee);
        if (tail) begin
            @(negedge clock);
            chk({tag, "_pulse"}, data_resultRDY, 0);
        end
    endtask

    initial begin
        int cnt;
        #12;
        chk("rst_res", data_result, 0);
        chk("rst_exc", data_exception, 0);
        chk("rst_rdy", data_resultRDY, 0);
        @(negedge clock);
        reset_n = 1'b1;

        op("m_7x-3", 1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 17, 32'hFFFF_FFEB, 0, 1);
        op("m_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 17, 32'h0000_0000, 1, 1);
        op("m_max", 1, 0, 32'h7FFF_FFFF, 32'h0000_0001, 17, 32'h7FFF_FFFF, 0, 1);
        op("m_min_x_m2", 1, 0, 32'h8000_0000, 32'hFFFF_FFFE, 17, 32'h0000_0000, 1, 1);
        op("m_min_x_1", 1, 0, 32'h8000_0000, 32'h0000_0001, 17, 32'h8000_0000, 0, 1);
        op("m_m1_x_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 32'h0000_0001, 0, 1);
        op("d_m100_7", 0, 1, 32'hFFFF_FF9C, 32'h0000_0007, 33, 32'hFFFF_FFF2, 0, 1);
        op("d_100_m7", 0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 0, 1);
        op("d_m100_m7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'h0000_000E, 0, 1);
        op("d_by0", 0, 1, 32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0000, 1, 1);
        op("d_minm1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1, 1);
        op("both", 1, 1, 32'h0000_0009, 32'h0000_0000, 17, 32'h0000_0000, 0, 1);

        // abort a divide at cycle 10 with a multiply
        cnt = 0;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        @(posedge clock);
        for (int c = 1; c < 10; c++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (data_resultRDY) cnt++;
        end
        chk("abort_pre", cnt, 0);
        op("restart", 1, 0, 32'd6, 32'd7, 17, 32'd42, 0, 1);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (data_resultRDY) cnt++;
        end
        chk("abort_norf", cnt, 0);
        chk("hold_res", data_result, 42);

        op("d_1000_3", 0, 1, 32'd1000, 32'd3, 33, 32'd333, 0, 0);
        op("b2b", 1, 0, 32'd11, 32'hFFFF_FFFB, 17, 32'hFFFF_FFC9, 0, 1);

        // asynchronous reset mid-multiply
        ctrl_MULT = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        @(posedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("arst_res", data_result, 0);
        chk("arst_exc", data_exception, 0);
        chk("arst_rdy", data_resultRDY, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (data_resultRDY) cnt++;
        end
        chk("arst_norf", cnt, 0);
        op("post_rst", 1, 0, 32'd3, 32'd4, 17, 32'd12, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
